// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold limit; registered grant one cycle after request.
// A requester may be preempted after MAX_HOLD cycles only while another request is pending.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] owner, owner_nxt;
    logic [3:0] hcnt, hcnt_nxt;
    logic [7:0] gnt_nxt;
    logic [2:0] idx_nxt;
    logic       vld_nxt;
    logic [7:0] others;

    // First set bit of r visiting base, base+1, ... (mod 8); the loop runs
    // backwards so the smallest offset from base is the last assignment.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [2:0] sel;
        sel = '0;
        for (int i = 7; i >= 0; i--) begin
            if (r[base + 3'(i)]) sel = base + 3'(i);
        end
        return sel;
    endfunction

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        hcnt_nxt  = hcnt;
        gnt_nxt   = '0;
        idx_nxt   = '0;
        vld_nxt   = 1'b0;
        others    = req & ~(8'd1 << owner);
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    owner_nxt = rr_pick(req, ptr);
                    hcnt_nxt  = 4'd1;
                    gnt_nxt   = 8'd1 << owner_nxt;
                    idx_nxt   = owner_nxt;
                    vld_nxt   = 1'b1;
                end
            end
            GRANT: begin
                // Release and preemption share the hand-off path; the owner is
                // searched last because the search starts just after it.
                if (!req[owner] || (hcnt >= HOLD_LIM && |others)) begin
                    ptr_nxt = owner + 3'd1;
                    if (|others) begin
                        owner_nxt = rr_pick(others, owner + 3'd1);
                        hcnt_nxt  = 4'd1;
                        gnt_nxt   = 8'd1 << owner_nxt;
                        idx_nxt   = owner_nxt;
                        vld_nxt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        hcnt_nxt  = '0;
                    end
                end else begin
                    hcnt_nxt = (hcnt == 4'hF) ? hcnt : hcnt + 4'd1;
                    gnt_nxt  = gnt;
                    idx_nxt  = gnt_idx;
                    vld_nxt  = gnt_vld;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            hcnt    <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            hcnt    <= hcnt_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural arbitration model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;
    localparam int WAIT_MAX = 7 * MAX_HOLD + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = '0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    // owner < 0 means nobody holds the grant; hold counts cycles held.
    typedef struct {
        int owner;
        int ptr;
        int hold;
    } mdl_t;

    mdl_t       m = '{-1, 0, 0};
    bit         started = 1'b0;
    logic [7:0] req_smp = '0;
    logic       rst_smp = 1'b0;
    int         waitc[8];

    function automatic int first_from(logic [7:0] r, int s);
        for (int k = 0; k < 8; k++) begin
            if (r[(s + k) % 8]) return (s + k) % 8;
        end
        return -1;
    endfunction

    function automatic mdl_t mstep(mdl_t c, logic rst, logic [7:0] r);
        mdl_t       n;
        logic [7:0] oth;
        n = c;
        if (!rst) begin
            n.owner = -1;
            n.ptr   = 0;
            n.hold  = 0;
            return n;
        end
        if (c.owner < 0) begin
            if (r != 0) begin
                n.owner = first_from(r, c.ptr);
                n.hold  = 1;
            end
            return n;
        end
        oth = r;
        oth[c.owner] = 1'b0;
        if (!r[c.owner] || (c.hold >= MAX_HOLD && oth != 0)) begin
            n.ptr = (c.owner + 1) % 8;
            if (oth != 0) begin
                n.owner = first_from(oth, n.ptr);
                n.hold  = 1;
            end else begin
                n.owner = -1;
                n.hold  = 0;
            end
        end else begin
            n.hold = (c.hold + 1 > 15) ? 15 : c.hold + 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] eg, input logic [2:0] ei, input logic ev);
        check({name, "_gnt"}, gnt, eg);
        check({name, "_idx"}, gnt_idx, ei);
        check({name, "_vld"}, gnt_vld, ev);
    endtask

    always @(posedge clk) begin
        m       <= mstep(m, rst_n, req);
        req_smp <= req;
        rst_smp <= rst_n;
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_gnt", gnt, (m.owner < 0) ? 32'd0 : (32'd1 << m.owner));
            check("model_idx", gnt_idx, (m.owner < 0) ? 32'd0 : m.owner);
            check("model_vld", gnt_vld, m.owner >= 0);
            check("onehot0", $onehot0(gnt), 1);
            for (int i = 0; i < 8; i++) begin
                if (rst_smp && req_smp[i] && !gnt[i]) waitc[i]++;
                else waitc[i] = 0;
                if (req_smp[i]) check("wait_bound", waitc[i] <= WAIT_MAX, 1);
            end
        end
    end

    int b;

    initial begin
        for (int i = 0; i < 8; i++) waitc[i] = 0;
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        lit("reset", 8'h00, 3'd0, 1'b0);

        rst_n = 1'b1;
        req   = 8'h24;
        @(negedge clk);
        lit("first_grant", 8'h04, 3'd2, 1'b1);
        check("ptr_unchanged", m.ptr, 0);
        @(negedge clk);
        lit("grant_held", 8'h04, 3'd2, 1'b1);

        req = 8'h20;
        @(negedge clk);
        lit("handoff", 8'h20, 3'd5, 1'b1);
        check("ptr_after_release", m.ptr, 3);

        req = 8'h00;
        @(negedge clk);
        lit("idle", 8'h00, 3'd0, 1'b0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            lit("rotate", 8'h01 << ((k / 4) % 8), 3'((k / 4) % 8), 1'b1);
        end

        req = 8'h40;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lit("solo", 8'h40, 3'd6, 1'b1);
        end
        check("solo_hold_sat", m.hold, 15);

        req = 8'h10;
        @(negedge clk);
        lit("pre_reset", 8'h10, 3'd4, 1'b1);
        req   = 8'hFF;
        rst_n = 1'b0;
        @(negedge clk);
        lit("reset_mid", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        lit("post_reset", 8'h01, 3'd0, 1'b1);

        repeat (10000) begin
            b = int'($urandom_range(0, 9));
            if (b < 2) begin
                req = 8'($urandom);
            end else if (b < 5) begin
                b = int'($urandom_range(0, 7));
                req[b] = ~req[b];
            end
            @(negedge clk);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
